if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller for the five-stage RV32I core. Owns the PC and drives the word address of the combinational instruction ROM. Buffers fetched words in a 2-entry prefetch queue feeding decode under a valid/ready handshake. Applies redirects from EX (taken branch, jal, jalr) by flushing the queue and reloading the PC, and parks fetch on a self-loop `jal` (the program's `done:` idiom).

## Interface
- ADDR_W, 6: ROM word-address width; ROM covers PC bytes 0 .. 4·2^ADDR_W−1
- RESET_PC, 32'h0000_0000: PC loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- rom_data  in  32  ROM output for rom_addr, same cycle
- if_valid  out  1  queue head holds an instruction
- if_instr  out  32  head instruction
- if_pc  out  32  head PC
- if_pred_taken  out  1  head was predicted taken at fetch (0 without STATIC_PREDICT_EN)
- id_ready  in  1  decode accepts head; pop = if_valid & id_ready
- redirect_valid  in  1  EX redirect this cycle
- redirect_pc  in  32  redirect target
- halted  out  1  fetch parked in HALT
- misalign  out  1  sticky; set when redirect_pc[1:0] ≠ 0

## Operation
- State: pc[31:0], 2-entry queue {pc, instr, pred} with rd/wr pointers and count (0..2), FSM {BOOT, RUN, HALT}.
- Reset: pc=RESET_PC, count=0, state=BOOT, misalign=0; outputs: if_valid=0, if_instr=0, if_pc=0, if_pred_taken=0, halted=0.
- BOOT: one cycle, no push; → RUN.
- RUN push condition: no redirect and (count<2 or pop). Push {pc, rom_data, pred}; pc ← next_pc.
- next_pc = pc+4, except under STATIC_PREDICT_EN (see Configuration).
- Self-loop detect: rom_data == 32'h0000_006F with any rd (opcode 1101111, imm=0) → pushed normally, pc unchanged, → HALT.
- HALT: no pushes; queue drains normally; halted=1.
- Redirect (any state): queue flushed (count=0, pointers reset), pc ← {redirect_pc[31:2],2'b00}, no push that cycle, state → RUN. If redirect_pc[1:0]≠0, misalign ← 1 (cleared only by reset).
- Priority: redirect > push; redirect with simultaneous pop: pop counts as consumed, then flush.
- Full (count=2) and pop: push allowed same edge; count stays 2.
- Full, no pop: pc and rom_addr hold; no push.
- PC beyond ROM range: rom_addr wraps mod 2^ADDR_W, upper PC bits still advance; if_pc reports full PC.
- Arithmetic: pc+4 and branch targets mod 2^32.

## Timing
- Fetch-to-decode latency: 1 cycle (word pushed at edge N is if_valid after edge N).
- First instruction: valid after 2nd rising edge post-reset (BOOT then first push).
- Redirect at edge N: if_valid=0 after N; target instruction valid after edge N+1 (1-cycle bubble).
- Sustained throughput: 1 instr/cycle with id_ready=1.
- Reset deassertion mid-operation: all state returns to reset values immediately (async), no partial push.

## Configuration
- STATIC_PREDICT_EN defined: predecode rom_data at push. B-type (opcode 1100011) with imm sign bit 1 → next_pc = pc + B-imm, pred=1. JAL non-self-loop → next_pc = pc + J-imm, pred=1. Otherwise pc+4, pred=0. EX still issues redirect on misprediction; fetch never self-corrects.
- Undefined: next_pc always pc+4; if_pred_taken tied 0; no predecode logic.

## Test plan
- Reset then id_ready=1, ROM from program image: if_pc sequence 0x0, 0x4; if_instr 0x00003F37 then 0x02000FE7.
- Redirect_pc=0x20 asserted on cycle after jalr pops: queue flushed, next valid if_pc=0x20, if_instr=0x00001C63, one bubble.
- id_ready=0 for 5 cycles: count saturates at 2, rom_addr frozen, if_pc stable; release → 0x8, 0xC, 0x10 back-to-back.
- Fetch reaches 0x1C (0x00000F6F): halted=1 after push, no further pushes; redirect_pc=0x8 → halted=0, if_pc=0x8 next valid.
- Redirect_pc=0x22: misalign=1 sticky, fetch resumes at 0x20; persists until rst_n low.
- STATIC_PREDICT_EN: fetch of 0xFC000AE3 at 0x34 → next if_pc=0x08, if_pred_taken=1; macro undefined → next if_pc=0x38, if_pred_taken=0.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction ROM port, decode handshake and EX redirect.
// The master modport is the fetch controller; the slave modport is its environment.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic              id_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  modport master (
    output rom_addr, if_valid, if_instr, if_pc, if_pred_taken,
    input  rom_data, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  rom_addr, if_valid, if_instr, if_pc, if_pred_taken,
    output rom_data, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// RV32I instruction-fetch controller: PC, 2-entry prefetch queue, EX redirects, self-loop halt.
// Optional static branch/jal prediction at fetch is enabled with `define STATIC_PREDICT_EN.
module if_fetch_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_ctrl_if.master        bus,
  output logic                   halted,
  output logic                   misalign
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic [31:0] pred_pc;
  logic        pred_bit;
  logic [31:0] instr_word;
  logic        fetch_en;
  logic        pop;
  logic        push;
  logic        self_loop;

  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        q_pred  [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  assign instr_word = bus.rom_data;
  assign seq_pc     = pc + 32'd4;

  // jal x?, 0 with any rd: the program parks itself here, so fetch stops too
  assign self_loop = (instr_word & 32'hFFFF_F07F) == 32'h0000_006F;

  assign pop  = (count != 2'd0) && bus.id_ready;
  assign push = fetch_en && !bus.redirect_valid && ((count != 2'd2) || pop);

`ifdef STATIC_PREDICT_EN
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_branch;
  logic        is_jal;

  assign b_imm = {{20{instr_word[31]}}, instr_word[7], instr_word[30:25],
                  instr_word[11:8], 1'b0};
  assign j_imm = {{12{instr_word[31]}}, instr_word[19:12], instr_word[20],
                  instr_word[30:21], 1'b0};
  assign is_branch = instr_word[6:0] == 7'b1100011;
  assign is_jal    = instr_word[6:0] == 7'b1101111;

  // Backward branches and non-parking jals are assumed taken
  always_comb begin
    pred_pc  = seq_pc;
    pred_bit = 1'b0;
    if (is_branch && instr_word[31]) begin
      pred_pc  = pc + b_imm;
      pred_bit = 1'b1;
    end else if (is_jal && !self_loop) begin
      pred_pc  = pc + j_imm;
      pred_bit = 1'b1;
    end
  end
`else
  assign pred_pc  = seq_pc;
  assign pred_bit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        BOOT:    state_next = RUN;
        RUN:     if (push && self_loop) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_en = 1'b0;
    halted   = 1'b0;
    case (state)
      RUN:     fetch_en = 1'b1;
      HALT:    halted   = 1'b1;
      default: ;
    endcase
  end

  // A parked self-loop keeps its own PC so a later redirect is the only way out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[31:2], 2'b00};
    end else if (push && !self_loop) begin
      pc <= pred_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

  // Flush wins over any same-cycle pop or push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_pred[i]  <= 1'b0;
      end
    end else if (bus.redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= pc;
        q_instr[wr_ptr] <= instr_word;
        q_pred[wr_ptr]  <= pred_bit;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.rom_addr      = pc[ADDR_W+1:2];
  assign bus.if_valid      = count != 2'd0;
  assign bus.if_instr      = bus.if_valid ? q_instr[rd_ptr] : 32'h0;
  assign bus.if_pc         = bus.if_valid ? q_pc[rd_ptr]    : 32'h0;
  assign bus.if_pred_taken = bus.if_valid && q_pred[rd_ptr];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed program-image scenarios plus a randomized run
// checked against a queue-based model of the fetch rules.
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;
  logic misalign;
  int   check_cnt = 0;
  int   pass_cnt = 0;

  if_fetch_ctrl_if #(.ADDR_W(6)) bus ();

  if_fetch_ctrl #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .halted   (halted),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  entry_t      m_q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_mis;

`ifdef STATIC_PREDICT_EN
  localparam logic [31:0] EXP_AFTER_BR = 32'h08;
  localparam logic        EXP_BR_PRED  = 1'b1;
`else
  localparam logic [31:0] EXP_AFTER_BR = 32'h38;
  localparam logic        EXP_BR_PRED  = 1'b0;
`endif

  function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                  output logic [31:0] npc, output logic p);
    int signed off;
    npc = pc + 32'd4;
    p   = 1'b0;
`ifdef STATIC_PREDICT_EN
    if (w[6:0] == 7'h63 && w[31]) begin
      off = -4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      npc = pc + 32'(off);
      p   = 1'b1;
    end else if (w[6:0] == 7'h6F && (w & 32'hFFFF_F07F) != 32'h6F) begin
      off = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      if (w[31]) off = off - (1 << 20);
      npc = pc + 32'(off);
      p   = 1'b1;
    end
`else
    off = 0;
    if (w == 32'hFFFF_FFFF && off != 0) p = 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_mode = M_BOOT;
    m_mis  = 1'b0;
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    logic [31:0] npc;
    logic        p;
    bit          can_push;
    w = rom[m_pc[7:2]];
    if (rv) begin
      m_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_mode = M_RUN;
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      can_push = (m_mode == M_RUN) && (m_q.size() < 2 || rdy);
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (can_push) begin
        predict(m_pc, w, npc, p);
        m_q.push_back('{pc: m_pc, instr: w, pred: p});
        if ((w & 32'hFFFF_F07F) == 32'h0000_006F) m_mode = M_HALT;
        else m_pc = npc;
      end
    end
  endtask

  task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    model_step(rdy, rv, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL rst_valid got=%b exp=0", bus.if_valid); else pass_cnt++;
    check_cnt++; if (bus.if_instr !== 32'h0) $display("[TB] FAIL rst_instr got=%h exp=0", bus.if_instr); else pass_cnt++;
    check_cnt++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL rst_pc got=%h exp=0", bus.if_pc); else pass_cnt++;
    check_cnt++; if (bus.if_pred_taken !== 1'b0) $display("[TB] FAIL rst_pred got=%b exp=0", bus.if_pred_taken); else pass_cnt++;
    check_cnt++; if ({halted, misalign} !== 2'b00) $display("[TB] FAIL rst_flags got=%b exp=00", {halted, misalign}); else pass_cnt++;
    check_cnt++; if (bus.rom_addr !== 6'd0) $display("[TB] FAIL rst_addr got=%h exp=0", bus.rom_addr); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL boot_bubble got=%b exp=0", bus.if_valid); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) $display("[TB] FAIL first_pc got=%b/%h exp=1/0", bus.if_valid, bus.if_pc); else pass_cnt++;
    check_cnt++; if (bus.if_instr !== 32'h0000_3F37) $display("[TB] FAIL first_instr got=%h exp=00003f37", bus.if_instr); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h4 || bus.if_instr !== 32'h0200_0FE7) $display("[TB] FAIL second got=%h/%h exp=4/02000fe7", bus.if_pc, bus.if_instr); else pass_cnt++;
  endtask

  task automatic test_redirect();
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h8) $display("[TB] FAIL after_jalr got=%h exp=8", bus.if_pc); else pass_cnt++;
    tick(1, 1, 32'h20);
    check_cnt++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL redir_bubble got=%b exp=0", bus.if_valid); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h20) $display("[TB] FAIL redir_pc got=%b/%h exp=1/20", bus.if_valid, bus.if_pc); else pass_cnt++;
    check_cnt++; if (bus.if_instr !== 32'h0000_1C63) $display("[TB] FAIL redir_instr got=%h exp=00001c63", bus.if_instr); else pass_cnt++;
  endtask

  task automatic test_stall();
    tick(0, 1, 32'h8);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      if (i >= 1) begin
        check_cnt++; if (bus.if_pc !== 32'h8 || bus.rom_addr !== 6'd4) $display("[TB] FAIL stall_hold got=%h/%h exp=8/4", bus.if_pc, bus.rom_addr); else pass_cnt++;
      end
    end
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC) $display("[TB] FAIL release_1 got=%b/%h exp=1/c", bus.if_valid, bus.if_pc); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10) $display("[TB] FAIL release_2 got=%b/%h exp=1/10", bus.if_valid, bus.if_pc); else pass_cnt++;
  endtask

  task automatic test_halt();
    int n = 0;
    while (halted !== 1'b1 && n < 8) begin
      tick(1, 0, 0);
      n++;
    end
    check_cnt++; if (halted !== 1'b1 || n != 2) $display("[TB] FAIL halt_reach got=%b after %0d exp=1 after 2", halted, n); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h1C || bus.if_instr !== 32'h0000_0F6F) $display("[TB] FAIL halt_head got=%h/%h exp=1c/00000f6f", bus.if_pc, bus.if_instr); else pass_cnt++;
    tick(1, 0, 0);
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b0 || halted !== 1'b1 || bus.rom_addr !== 6'd7) $display("[TB] FAIL halt_drain got=%b/%b/%h exp=0/1/7", bus.if_valid, halted, bus.rom_addr); else pass_cnt++;
    tick(1, 1, 32'h8);
    check_cnt++; if (halted !== 1'b0) $display("[TB] FAIL unhalt got=%b exp=0", halted); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8) $display("[TB] FAIL unhalt_pc got=%b/%h exp=1/8", bus.if_valid, bus.if_pc); else pass_cnt++;
  endtask

  task automatic test_misalign();
    tick(1, 1, 32'h22);
    check_cnt++; if (misalign !== 1'b1 || bus.rom_addr !== 6'd8) $display("[TB] FAIL misalign_set got=%b/%h exp=1/8", misalign, bus.rom_addr); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h20 || bus.if_instr !== 32'h0000_1C63) $display("[TB] FAIL misalign_pc got=%h/%h exp=20/00001c63", bus.if_pc, bus.if_instr); else pass_cnt++;
    tick(1, 1, 32'h8);
    tick(1, 0, 0);
    check_cnt++; if (misalign !== 1'b1) $display("[TB] FAIL misalign_sticky got=%b exp=1", misalign); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_cnt++; if ({misalign, halted, bus.if_valid} !== 3'b000 || bus.rom_addr !== 6'd0) $display("[TB] FAIL async_rst got=%b/%h exp=000/0", {misalign, halted, bus.if_valid}, bus.rom_addr); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_predict();
    tick(1, 1, 32'h34);
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h34 || bus.if_pred_taken !== EXP_BR_PRED) $display("[TB] FAIL br_head got=%h/%b exp=34/%b", bus.if_pc, bus.if_pred_taken, EXP_BR_PRED); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== EXP_AFTER_BR || bus.if_pred_taken !== 1'b0) $display("[TB] FAIL br_next got=%h/%b exp=%h/0", bus.if_pc, bus.if_pred_taken, EXP_AFTER_BR); else pass_cnt++;
  endtask

  task automatic test_wrap();
    tick(1, 1, 32'h104);
    check_cnt++; if (bus.rom_addr !== 6'd1) $display("[TB] FAIL wrap_addr got=%h exp=1", bus.rom_addr); else pass_cnt++;
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'h104 || bus.if_instr !== 32'h0200_0FE7) $display("[TB] FAIL wrap_head got=%h/%h exp=104/02000fe7", bus.if_pc, bus.if_instr); else pass_cnt++;
    tick(1, 1, 32'hFFFF_FFFC);
    tick(1, 0, 0);
    check_cnt++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.rom_addr !== 6'd0) $display("[TB] FAIL wrap32 got=%h/%h exp=fffffffc/0", bus.if_pc, bus.rom_addr); else pass_cnt++;
  endtask

  task automatic test_random();
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    entry_t      h;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
      tick(rdy, rv, rpc);
      check_cnt++;
      if (bus.if_valid !== (m_q.size() != 0) || halted !== (m_mode == M_HALT) ||
          misalign !== m_mis || bus.rom_addr !== m_pc[7:2])
        $display("[TB] FAIL rand_ctrl cyc %0d got=v%b h%b m%b a%h exp=v%b h%b m%b a%h", c,
                 bus.if_valid, halted, misalign, bus.rom_addr,
                 m_q.size() != 0, m_mode == M_HALT, m_mis, m_pc[7:2]);
      else pass_cnt++;
      if (m_q.size() != 0) begin
        h = m_q[0];
        check_cnt++;
        if (bus.if_pc !== h.pc || bus.if_instr !== h.instr || bus.if_pred_taken !== h.pred)
          $display("[TB] FAIL rand_head cyc %0d got=%h/%h/%b exp=%h/%h/%b", c,
                   bus.if_pc, bus.if_instr, bus.if_pred_taken, h.pc, h.instr, h.pred);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h0000_3F37;
    rom[1]  = 32'h0200_0FE7;
    rom[2]  = 32'h0000_0013;
    rom[3]  = 32'h0010_0093;
    rom[4]  = 32'h0020_8113;
    rom[5]  = 32'h0031_0193;
    rom[6]  = 32'h0041_8213;
    rom[7]  = 32'h0000_0F6F;
    rom[8]  = 32'h0000_1C63;
    for (int i = 9; i < 13; i++) rom[i] = 32'h0000_0013;
    rom[13] = 32'hFC00_0AE3;
    rom[14] = 32'h0000_0013;
    rom[15] = 32'h0000_0013;
    rom[63] = 32'h0000_0013;

    test_reset();
    test_boot_fetch();
    test_redirect();
    test_stall();
    test_halt();
    test_misalign();
    test_reset_mid();
    test_predict();
    test_wrap();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
